ras_ctrl: RTL and testbench
===========================

// Module: ras_ctrl
// PURPOSE
//  Sequencer in front of the return-address-stack datapath (push/pop/branch/close strobes).
//  Accepts call/return events from decode and branch open/resolve events from execute.
//  Enforces one open speculative branch level, gives resolve priority, and tracks occupancy.
//  Qualifies the stack's 1-cycle-latency read data as a return prediction.
// PARAMETERS
//  DEPTH  16  stack entries; must match the datapath instance
//  WIDTH  32  return-address width
//  ADDR   4   clog2(DEPTH); occupancy counter is ADDR+1 bits
// PORTS
//  clk               in   1      clock
//  rst               in   1      synchronous, active-high reset
//  call_valid        in   1      decode: call; push call_addr
//  call_addr         in   WIDTH  return address to push
//  ret_valid         in   1      decode: return; pop a prediction
//  ev_ready          out  1      call/ret accepted this cycle (combinational: !(br_valid|br_invalid))
//  br_open           in   1      execute: open speculative branch
//  br_ready          out  1      br_open accepted this cycle (state==IDLE && no resolve)
//  br_valid          in   1      open branch resolved correct
//  br_invalid        in   1      open branch mispredicted
//  ras_push/ras_pop  out  1      datapath strobes (combinational)
//  ras_branch        out  1      datapath branch strobe
//  ras_close_valid   out  1      datapath close strobe, branch kept
//  ras_close_invalid out  1      datapath close strobe, branch discarded
//  ras_din           out  WIDTH  = call_addr
//  ras_dout          in   WIDTH  datapath read data
//  pred_valid        out  1      ras_dout is a valid prediction this cycle
//  pred_addr         out  WIDTH  = ras_dout
//  pred_miss         out  1      previous cycle's return found an empty stack
//  occupancy         out  ADDR+1 live entries, 0..DEPTH
// BEHAVIOUR
//  Reset (sync, any cycle, including mid-branch):
//   state=IDLE; occupancy=0; checkpoint=0; pred_valid=0; pred_miss=0.
//   The datapath has no reset, so after rst it is treated as empty.
//  FSM states:
//   IDLE: no open branch.
//    br_open && br_ready -> ras_branch=1 for one cycle; checkpoint<=occupancy (pre-op value); go SPEC.
//   SPEC: branch open; br_ready=0.
//    br_valid -> ras_close_valid=1; go IDLE.
//    br_invalid -> ras_close_invalid=1; occupancy<=checkpoint; go IDLE.
//    br_valid && br_invalid together: invalid wins.
//   Resolve inputs in IDLE are ignored but still deassert ev_ready.
//  Resolve priority: a call/ret presented in a resolve cycle is not accepted; decode holds it.
//  Accepted events:
//   call only -> ras_push.
//   ret only with occupancy>0 -> ras_pop.
//   call+ret together -> ras_push && ras_pop (datapath replace).
//   ret with occupancy==0 -> no ras_pop; pred_miss=1 next cycle.
//   ras_branch may coincide with push/pop; checkpoint takes the pre-op occupancy.
//  Occupancy update (registered):
//   push only: min(occ+1, DEPTH); at full the oldest entry is overwritten and occ stays DEPTH.
//   pop only: occ-1.
//   push+pop: unchanged (occ==0 case counts as push-only).
//   br_invalid restore overrides the same-cycle update; no call/ret is accepted that cycle anyway.
//  Latency: pred_valid=1 exactly one cycle after a cycle with ras_pop=1; otherwise 0.
//   pred_addr = ras_dout (no extra register).
// STRUCTURE
//  ras_pkg:
//   typedef enum logic {IDLE, SPEC} ras_ctrl_state_t;
//   RAS_DEPTH, RAS_WIDTH, RAS_ADDR default constants.
//  Sub-module ras_occ_counter: saturating up/down counter with load port for the checkpoint restore.
//  Top instantiates ras_ctrl next to the ras datapath; strobes connect 1:1.
// TESTING
//  1. rst; 3 calls (0x100,0x200,0x300); ret -> ras_pop; next cycle pred_valid=1,
//     pred_addr=0x300; occupancy 3->2.
//  2. ret with occupancy=0 -> ras_pop=0; next cycle pred_miss=1, pred_valid=0; occupancy stays 0.
//  3. occ=2; br_open; 2 calls (occ=4); br_invalid -> ras_close_invalid=1; occupancy=2; state IDLE.
//     Same sequence with br_valid -> occupancy=4.
//  4. In SPEC, br_open -> br_ready=0. call+br_valid same cycle -> ev_ready=0, no push.
//     Call held -> push the next cycle.
//  5. 17 calls with DEPTH=16 -> occupancy saturates at 16. call+ret same cycle at occ=16 -> push&&pop; occ=16.
//  6. rst asserted in SPEC with occ=5 -> next cycle IDLE, occupancy=0, br_ready=1, no strobes asserted.

Source files
------------

// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared types and default sizes for the return-address-stack sequencer
package ras_pkg;

  typedef enum logic {IDLE, SPEC} ras_ctrl_state_t;

  localparam int RAS_DEPTH = 16;
  localparam int RAS_WIDTH = 32;
  localparam int RAS_ADDR  = 4;

endpackage

// File: rtl/ras_occ_counter.sv
// rtl/ras_occ_counter.sv - saturating up/down occupancy counter with checkpoint load
module ras_occ_counter
  import ras_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int ADDR  = RAS_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          load,
  input  logic [ADDR:0] load_val,
  output logic [ADDR:0] count
);

  localparam logic [ADDR:0] MAX = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] ONE = 1;

  // Load wins over inc/dec; at full a push overwrites the oldest entry, so the count holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && !dec) begin
      if (count != MAX) count <= count + ONE;
    end else if (dec && !inc) begin
      if (count != '0) count <= count - ONE;
    end
  end

endmodule

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - call/return and speculative-branch sequencer for the return-address stack
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int WIDTH = RAS_WIDTH,
  parameter int ADDR  = RAS_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             call_valid,
  input  logic [WIDTH-1:0] call_addr,
  input  logic             ret_valid,
  output logic             ev_ready,
  input  logic             br_open,
  output logic             br_ready,
  input  logic             br_valid,
  input  logic             br_invalid,
  output logic             ras_push,
  output logic             ras_pop,
  output logic             ras_branch,
  output logic             ras_close_valid,
  output logic             ras_close_invalid,
  output logic [WIDTH-1:0] ras_din,
  input  logic [WIDTH-1:0] ras_dout,
  output logic             pred_valid,
  output logic [WIDTH-1:0] pred_addr,
  output logic             pred_miss,
  output logic [ADDR:0]    occupancy
);

  ras_ctrl_state_t state;
  logic [ADDR:0]   checkpoint;
  logic            resolve;
  logic            accept_ret;

  // Resolve strobes take the cycle: decode events stall even when no branch is open.
  assign resolve    = br_valid | br_invalid;
  assign ev_ready   = !resolve;
  assign br_ready   = (state == IDLE) && !resolve;
  assign accept_ret = ret_valid && ev_ready;

  assign ras_push          = call_valid && ev_ready;
  assign ras_pop           = accept_ret && (occupancy != '0);
  assign ras_branch        = br_open && br_ready;
  assign ras_close_invalid = (state == SPEC) && br_invalid;
  assign ras_close_valid   = (state == SPEC) && br_valid && !br_invalid;
  assign ras_din           = call_addr;
  assign pred_addr         = ras_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      checkpoint <= '0;
      pred_valid <= 1'b0;
      pred_miss  <= 1'b0;
    end else begin
      pred_valid <= ras_pop;
      pred_miss  <= accept_ret && (occupancy == '0);
      if (state == IDLE) begin
        if (ras_branch) begin
          checkpoint <= occupancy;
          state      <= SPEC;
        end
      end else if (resolve) begin
        state <= IDLE;
      end
    end
  end

  ras_occ_counter #(
    .DEPTH(DEPTH),
    .ADDR (ADDR)
  ) u_occ (
    .clk     (clk),
    .rst     (rst),
    .inc     (ras_push),
    .dec     (ras_pop),
    .load    (ras_close_invalid),
    .load_val(checkpoint),
    .count   (occupancy)
  );

endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - directed self-checking bench for ras_ctrl with a behavioural stack
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        call_valid;
  logic [31:0] call_addr;
  logic        ret_valid;
  logic        ev_ready;
  logic        br_open;
  logic        br_ready;
  logic        br_valid;
  logic        br_invalid;
  logic        ras_push;
  logic        ras_pop;
  logic        ras_branch;
  logic        ras_close_valid;
  logic        ras_close_invalid;
  logic [31:0] ras_din;
  logic [31:0] ras_dout;
  logic        pred_valid;
  logic [31:0] pred_addr;
  logic        pred_miss;
  logic [4:0]  occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ras_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .call_valid       (call_valid),
    .call_addr        (call_addr),
    .ret_valid        (ret_valid),
    .ev_ready         (ev_ready),
    .br_open          (br_open),
    .br_ready         (br_ready),
    .br_valid         (br_valid),
    .br_invalid       (br_invalid),
    .ras_push         (ras_push),
    .ras_pop          (ras_pop),
    .ras_branch       (ras_branch),
    .ras_close_valid  (ras_close_valid),
    .ras_close_invalid(ras_close_invalid),
    .ras_din          (ras_din),
    .ras_dout         (ras_dout),
    .pred_valid       (pred_valid),
    .pred_addr        (pred_addr),
    .pred_miss        (pred_miss),
    .occupancy        (occupancy)
  );

  // Circular stack with registered read data, standing in for the datapath.
  logic [31:0] mem [16];
  logic [3:0]  ptr = 4'd0;
  always @(posedge clk) begin
    if (ras_push && ras_pop) begin
      ras_dout <= mem[ptr];
      mem[ptr] <= ras_din;
    end else if (ras_push) begin
      mem[ptr + 4'd1] <= ras_din;
      ptr <= ptr + 4'd1;
    end else if (ras_pop) begin
      ras_dout <= mem[ptr];
      ptr <= ptr - 4'd1;
    end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    call_valid = 1'b0;
    call_addr  = 32'h0;
    ret_valid  = 1'b0;
    br_open    = 1'b0;
    br_valid   = 1'b0;
    br_invalid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic do_call(input logic [31:0] a);
    call_valid = 1'b1;
    call_addr  = a;
    step();
    clear_inputs();
    #1;
  endtask

  task automatic do_ret();
    ret_valid = 1'b1;
    step();
    clear_inputs();
    #1;
  endtask

  task automatic open_branch();
    br_open = 1'b1;
    #1;
    expect_eq("open_branch_strobe", ras_branch, 1);
    step();
    clear_inputs();
    #1;
  endtask

  initial begin
    do_reset();
    expect_eq("rst_occ", occupancy, 0);
    expect_eq("rst_pred_valid", pred_valid, 0);
    expect_eq("rst_pred_miss", pred_miss, 0);
    expect_eq("rst_br_ready", br_ready, 1);
    expect_eq("rst_ev_ready", ev_ready, 1);

    // 1: three calls then a return predicts the last address
    call_valid = 1'b1;
    call_addr  = 32'h100;
    #1;
    expect_eq("t1_push", ras_push, 1);
    expect_eq("t1_din", ras_din, 32'h100);
    step();
    clear_inputs();
    do_call(32'h200);
    do_call(32'h300);
    expect_eq("t1_occ3", occupancy, 3);
    ret_valid = 1'b1;
    #1;
    expect_eq("t1_pop", ras_pop, 1);
    step();
    clear_inputs();
    #1;
    expect_eq("t1_pred_valid", pred_valid, 1);
    expect_eq("t1_pred_addr", pred_addr, 32'h300);
    expect_eq("t1_occ2", occupancy, 2);
    step();
    expect_eq("t1_pred_valid_drop", pred_valid, 0);

    // 2: return on an empty stack
    do_ret();
    do_ret();
    expect_eq("t2_drained", occupancy, 0);
    ret_valid = 1'b1;
    #1;
    expect_eq("t2_no_pop", ras_pop, 0);
    step();
    clear_inputs();
    #1;
    expect_eq("t2_pred_miss", pred_miss, 1);
    expect_eq("t2_pred_valid", pred_valid, 0);
    expect_eq("t2_occ", occupancy, 0);
    step();
    expect_eq("t2_miss_drop", pred_miss, 0);

    // 3: mispredict restores the checkpoint, correct resolve keeps the pushes
    do_reset();
    do_call(32'h10);
    do_call(32'h20);
    open_branch();
    expect_eq("t3_br_ready_spec", br_ready, 0);
    do_call(32'h30);
    do_call(32'h40);
    expect_eq("t3_occ4", occupancy, 4);
    br_invalid = 1'b1;
    #1;
    expect_eq("t3_close_inv", ras_close_invalid, 1);
    expect_eq("t3_close_val_n", ras_close_valid, 0);
    expect_eq("t3_ev_ready", ev_ready, 0);
    step();
    clear_inputs();
    #1;
    expect_eq("t3_restore", occupancy, 2);
    expect_eq("t3_idle", br_ready, 1);
    open_branch();
    do_call(32'h50);
    do_call(32'h60);
    br_valid = 1'b1;
    #1;
    expect_eq("t3_close_val", ras_close_valid, 1);
    step();
    clear_inputs();
    #1;
    expect_eq("t3_keep", occupancy, 4);
    expect_eq("t3_idle2", br_ready, 1);

    // 3b: simultaneous resolve, invalid wins
    open_branch();
    do_call(32'h70);
    br_valid   = 1'b1;
    br_invalid = 1'b1;
    #1;
    expect_eq("t3b_inv", ras_close_invalid, 1);
    expect_eq("t3b_val_n", ras_close_valid, 0);
    step();
    clear_inputs();
    #1;
    expect_eq("t3b_occ", occupancy, 4);

    // 4: second open refused; call held across a resolve
    open_branch();
    br_open = 1'b1;
    #1;
    expect_eq("t4_br_ready", br_ready, 0);
    expect_eq("t4_no_branch", ras_branch, 0);
    br_open    = 1'b0;
    call_valid = 1'b1;
    call_addr  = 32'h400;
    br_valid   = 1'b1;
    #1;
    expect_eq("t4_ev_ready", ev_ready, 0);
    expect_eq("t4_no_push", ras_push, 0);
    step();
    br_valid = 1'b0;
    #1;
    expect_eq("t4_held_push", ras_push, 1);
    step();
    clear_inputs();
    #1;
    expect_eq("t4_occ", occupancy, 5);

    // 5: saturation and replace at full
    do_reset();
    for (int i = 0; i < 17; i++) do_call(32'h1000 + 32'(i));
    expect_eq("t5_sat", occupancy, 16);
    call_valid = 1'b1;
    call_addr  = 32'h2000;
    ret_valid  = 1'b1;
    #1;
    expect_eq("t5_push", ras_push, 1);
    expect_eq("t5_pop", ras_pop, 1);
    step();
    clear_inputs();
    #1;
    expect_eq("t5_occ", occupancy, 16);
    expect_eq("t5_pred_valid", pred_valid, 1);

    // 6: reset in the middle of a speculative branch
    do_reset();
    for (int i = 0; i < 5; i++) do_call(32'h3000 + 32'(i));
    open_branch();
    expect_eq("t6_occ5", occupancy, 5);
    do_reset();
    expect_eq("t6_occ", occupancy, 0);
    expect_eq("t6_br_ready", br_ready, 1);
    expect_eq("t6_push", ras_push, 0);
    expect_eq("t6_pop", ras_pop, 0);
    expect_eq("t6_branch", ras_branch, 0);
    expect_eq("t6_close_v", ras_close_valid, 0);
    expect_eq("t6_close_i", ras_close_invalid, 0);
    expect_eq("t6_pred_valid", pred_valid, 0);
    br_invalid = 1'b1;
    #1;
    expect_eq("t6_close_i_idle", ras_close_invalid, 0);
    step();
    clear_inputs();
    #1;
    expect_eq("t6_occ_hold", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
